// File: rtl/de_stage_pipe.sv
// de_stage_pipe: registered RV32I decode stage between IF and EX.
//
// Decodes one instruction per accepted handshake into register fields, a
// format-selected sign-extended immediate and control bits, and holds the
// result in an output register until EX consumes it. Load-use hazards against
// the instruction in EX hold the incoming instruction back, and every such
// stall cycle is counted in a saturating counter. Flush kills both the held
// and the incoming instruction.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           IF-side handshake
//   in_pc, in_ir                PC and instruction word from IF
//   flush                       redirect: drop held and incoming instruction
//   ex_mem_read, ex_rd          load-in-EX information for hazard detection
//   out_valid/out_ready         EX-side handshake
//   out_pc, out_ir              registered PC and instruction word
//   out_opcode/rd/rs1/rs2       fields of out_ir
//   out_imm                     sign-extended immediate
//   out_reg_write/mem_read/mem_write/illegal   decoded control bits
//   stall_cnt                   saturating count of hazard stall cycles
module de_stage_pipe #(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 16,
    parameter int CSR_LEGAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_ir,
    input  logic             flush,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_ir,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    // Sign-extend a 32-bit immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        logic signed [XLEN-1:0] w;
        w = XLEN'(v);
        return w;
    endfunction

    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    imm_fmt_e        dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_reg_write;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_illegal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;
    logic            accept;

    logic             out_valid_d,     out_valid_q;
    logic [XLEN-1:0]  out_pc_d,        out_pc_q;
    logic [31:0]      out_ir_d,        out_ir_q;
    logic [XLEN-1:0]  out_imm_d,       out_imm_q;
    logic             out_reg_write_d, out_reg_write_q;
    logic             out_mem_read_d,  out_mem_read_q;
    logic             out_mem_write_d, out_mem_write_q;
    logic             out_illegal_d,   out_illegal_q;
    logic [CNT_W-1:0] stall_cnt_d,     stall_cnt_q;

    // Decode of the incoming instruction
    always_comb begin
        dec_opcode    = in_ir[6:0];
        dec_rd        = in_ir[11:7];
        dec_rs1       = in_ir[19:15];
        dec_rs2       = in_ir[24:20];
        dec_fmt       = IMM_NONE;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        case (dec_opcode)
            OP_LOAD:   begin dec_reg_write = 1'b1; dec_mem_read = 1'b1; dec_fmt = IMM_I; uses_rs1 = 1'b1; end
            OP_IMM:    begin dec_reg_write = 1'b1; dec_fmt = IMM_I; uses_rs1 = 1'b1; end
            OP_REG:    begin dec_reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI:    begin dec_reg_write = 1'b1; dec_fmt = IMM_U; end
            OP_AUIPC:  begin dec_reg_write = 1'b1; dec_fmt = IMM_U; end
            OP_BRANCH: begin dec_fmt = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JAL:    begin dec_reg_write = 1'b1; dec_fmt = IMM_J; end
            OP_JALR:   begin dec_reg_write = 1'b1; dec_fmt = IMM_I; uses_rs1 = 1'b1; end
            OP_STORE:  begin dec_mem_write = 1'b1; dec_fmt = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_SYSTEM: dec_illegal = (CSR_LEGAL == 0);
            default:   dec_illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; never request them.
        if (dec_rd == 5'd0) begin
            dec_reg_write = 1'b0;
        end

        case (dec_fmt)
            IMM_I:   dec_imm = sext({{20{in_ir[31]}}, in_ir[31:20]});
            IMM_S:   dec_imm = sext({{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]});
            IMM_B:   dec_imm = sext({{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0});
            IMM_U:   dec_imm = sext({in_ir[31:12], 12'b0});
            IMM_J:   dec_imm = sext({{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0});
            default: dec_imm = '0;
        endcase

        hazard   = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (dec_rs1 == ex_rd)) || (uses_rs2 && (dec_rs2 == ex_rd)));
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    // Next state of the output register and stall counter
    always_comb begin
        out_valid_d     = out_valid_q;
        out_pc_d        = out_pc_q;
        out_ir_d        = out_ir_q;
        out_imm_d       = out_imm_q;
        out_reg_write_d = out_reg_write_q;
        out_mem_read_d  = out_mem_read_q;
        out_mem_write_d = out_mem_write_q;
        out_illegal_d   = out_illegal_q;
        stall_cnt_d     = stall_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            out_pc_d        = in_pc;
            out_ir_d        = in_ir;
            out_imm_d       = dec_imm;
            out_reg_write_d = dec_reg_write;
            out_mem_read_d  = dec_mem_read;
            out_mem_write_d = dec_mem_write;
            out_illegal_d   = dec_illegal;
        end else if (out_ready) begin
            // EX took the held instruction and nothing replaces it: bubble.
            out_valid_d = 1'b0;
        end

        if (hazard && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Output pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_ir_q        <= '0;
            out_imm_q       <= '0;
            out_reg_write_q <= 1'b0;
            out_mem_read_q  <= 1'b0;
            out_mem_write_q <= 1'b0;
            out_illegal_q   <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_pc_q        <= out_pc_d;
            out_ir_q        <= out_ir_d;
            out_imm_q       <= out_imm_d;
            out_reg_write_q <= out_reg_write_d;
            out_mem_read_q  <= out_mem_read_d;
            out_mem_write_q <= out_mem_write_d;
            out_illegal_q   <= out_illegal_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_ir        = out_ir_q;
    assign out_opcode    = out_ir_q[6:0];
    assign out_rd        = out_ir_q[11:7];
    assign out_rs1       = out_ir_q[19:15];
    assign out_rs2       = out_ir_q[24:20];
    assign out_imm       = out_imm_q;
    assign out_reg_write = out_reg_write_q;
    assign out_mem_read  = out_mem_read_q;
    assign out_mem_write = out_mem_write_q;
    assign out_illegal   = out_illegal_q;
    assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_de_stage_pipe.sv
// Testbench for de_stage_pipe: directed stimulus, a behavioural reference
// model compared every cycle, and hand-computed literal expectations.
// A second instance uses CSR_LEGAL=0 and CNT_W=2.
module tb_de_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_ir;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        out_ready;

    logic        in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, out_illegal;
    logic [31:0] out_pc, out_ir, out_imm;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2, out_reg_write2, out_mem_read2, out_mem_write2, out_illegal2;
    logic [31:0] out_pc2, out_ir2, out_imm2;
    logic [6:0]  out_opcode2;
    logic [4:0]  out_rd2, out_rs12, out_rs22;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    de_stage_pipe #(.XLEN(32), .CNT_W(16), .CSR_LEGAL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .flush(flush), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
    );

    de_stage_pipe #(.XLEN(32), .CNT_W(2), .CSR_LEGAL(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc(in_pc), .in_ir(in_ir), .flush(flush), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .out_valid(out_valid2), .out_ready(out_ready),
        .out_pc(out_pc2), .out_ir(out_ir2), .out_opcode(out_opcode2), .out_rd(out_rd2),
        .out_rs1(out_rs12), .out_rs2(out_rs22), .out_imm(out_imm2),
        .out_reg_write(out_reg_write2), .out_mem_read(out_mem_read2),
        .out_mem_write(out_mem_write2), .out_illegal(out_illegal2), .stall_cnt(stall_cnt2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rw, mr, mw, ill, u1, u2;
        logic [31:0] imm;
    } dec_t;

    function automatic int imm_i(input logic [31:0] ir);
        int v = int'(ir[31:20]);
        if (ir[31]) v = v - 4096;
        return v;
    endfunction
    function automatic int imm_s(input logic [31:0] ir);
        int v = int'(ir[31:25]) * 32 + int'(ir[11:7]);
        if (ir[31]) v = v - 4096;
        return v;
    endfunction
    function automatic int imm_b(input logic [31:0] ir);
        int v = int'(ir[7]) * 2048 + int'(ir[30:25]) * 32 + int'(ir[11:8]) * 2;
        if (ir[31]) v = v - 4096;
        return v;
    endfunction
    function automatic int imm_j(input logic [31:0] ir);
        int v = int'(ir[19:12]) * 4096 + int'(ir[20]) * 2048 + int'(ir[30:21]) * 2;
        if (ir[31]) v = v - 1048576;
        return v;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ir, input bit csr_legal);
        dec_t d;
        int   v;
        d = '0;
        v = 0;
        case (ir[6:0])
            7'b0000011: begin d.rw = 1; d.mr = 1; d.u1 = 1; v = imm_i(ir); end
            7'b0010011: begin d.rw = 1; d.u1 = 1; v = imm_i(ir); end
            7'b0110011: begin d.rw = 1; d.u1 = 1; d.u2 = 1; end
            7'b0110111,
            7'b0010111: begin d.rw = 1; v = int'(ir & 32'hFFFF_F000); end
            7'b1100011: begin d.u1 = 1; d.u2 = 1; v = imm_b(ir); end
            7'b1101111: begin d.rw = 1; v = imm_j(ir); end
            7'b1100111: begin d.rw = 1; d.u1 = 1; v = imm_i(ir); end
            7'b0100011: begin d.mw = 1; d.u1 = 1; d.u2 = 1; v = imm_s(ir); end
            7'b1110011: d.ill = !csr_legal;
            default:    d.ill = 1;
        endcase
        if (ir[11:7] == 5'd0) d.rw = 0;
        d.imm = 32'(v);
        return d;
    endfunction

    function automatic bit ref_hazard();
        dec_t d = ref_decode(in_ir, 1'b1);
        return in_valid && ex_mem_read && ex_rd != 5'd0 &&
               ((d.u1 && in_ir[19:15] == ex_rd) || (d.u2 && in_ir[24:20] == ex_rd));
    endfunction

    bit          m_valid = 0;
    logic [31:0] m_pc = 0, m_ir = 0;
    dec_t        m_dec = '0;
    bit          m_ill2 = 0;
    int          m_cnt = 0, m_cnt2 = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_pc = 0; m_ir = 0; m_dec = '0; m_ill2 = 0;
            m_cnt = 0; m_cnt2 = 0;
        end else begin
            bit haz, rdy;
            haz = ref_hazard();
            rdy = (!m_valid || out_ready) && !haz && !flush;
            if (haz && !flush) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
            end
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1; m_pc = in_pc; m_ir = in_ir;
                m_dec  = ref_decode(in_ir, 1'b1);
                m_ill2 = ref_decode(in_ir, 1'b0).ill;
            end else if (out_ready) m_valid = 0;
        end
    end

    // Every-cycle compare, after inputs settle and before the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            begin
                bit rdy;
                rdy = (!m_valid || out_ready) && !ref_hazard() && !flush;
                chk("in_ready", in_ready, rdy);
                chk("in_ready2", in_ready2, rdy);
                chk("out_valid", out_valid, m_valid);
                chk("out_valid2", out_valid2, m_valid);
                chk("stall_cnt", stall_cnt, 64'(m_cnt));
                chk("stall_cnt2", stall_cnt2, 64'(m_cnt2));
                if (m_valid) begin
                    chk("out_pc", out_pc, m_pc);
                    chk("out_ir", out_ir, m_ir);
                    chk("out_opcode", out_opcode, m_ir[6:0]);
                    chk("out_rd", out_rd, m_ir[11:7]);
                    chk("out_rs1", out_rs1, m_ir[19:15]);
                    chk("out_rs2", out_rs2, m_ir[24:20]);
                    chk("out_imm", out_imm, m_dec.imm);
                    chk("out_reg_write", out_reg_write, m_dec.rw);
                    chk("out_mem_read", out_mem_read, m_dec.mr);
                    chk("out_mem_write", out_mem_write, m_dec.mw);
                    chk("out_illegal", out_illegal, m_dec.ill);
                    chk("out_illegal2", out_illegal2, m_ill2);
                    chk("out_imm2", out_imm2, m_dec.imm);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
        in_valid = v; in_ir = ir; in_pc = pc;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_ir = 0; in_pc = 0; flush = 0;
        ex_mem_read = 0; ex_rd = 0; out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst stall_cnt", stall_cnt, 0);
        chk("rst out_imm", out_imm, 0);
        chk("rst out_pc", out_pc, 0);
        rst_n = 1;

        // addi x1,x0,5
        drive(1, 32'h00500093, 32'h100); step();
        chk("addi valid", out_valid, 1);
        chk("addi rd", out_rd, 1);
        chk("addi imm", out_imm, 5);
        chk("addi rw", out_reg_write, 1);
        chk("addi pc", out_pc, 32'h100);

        // sw x2,-4(x1), then auipc x3,0x12345
        drive(1, 32'hFE20AE23, 32'h104); step();
        chk("sw mw", out_mem_write, 1);
        chk("sw rw", out_reg_write, 0);
        chk("sw imm", out_imm, 32'hFFFFFFFC);
        drive(1, 32'h12345197, 32'h108); step();
        chk("auipc imm", out_imm, 32'h12345000);
        chk("auipc rw", out_reg_write, 1);

        // load-use hazard on add x3,x1,x2 for 3 cycles
        ex_mem_read = 1; ex_rd = 5'd1;
        drive(1, 32'h002081B3, 32'h10C);
        #1 chk("haz in_ready", in_ready, 0);
        repeat (3) step();
        chk("haz drained", out_valid, 0);
        chk("haz stall_cnt", stall_cnt, 3);
        ex_rd = 5'd0;
        #1 chk("exrd0 in_ready", in_ready, 1);
        step();
        chk("exrd0 valid", out_valid, 1);
        chk("exrd0 ir", out_ir, 32'h002081B3);
        chk("exrd0 stall", stall_cnt, 3);

        // backpressure; op-imm rs2 field matching ex_rd must not stall
        ex_mem_read = 1; ex_rd = 5'd31;
        out_ready = 0;
        drive(1, 32'hFFF00293, 32'h110);
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp in_ready", in_ready, 0);
            step();
            chk("bp hold ir", out_ir, 32'h002081B3);
            chk("bp hold valid", out_valid, 1);
        end
        out_ready = 1;
        #1 chk("bp release ready", in_ready, 1);
        step();
        chk("bp next ir", out_ir, 32'hFFF00293);
        chk("bp next imm", out_imm, 32'hFFFFFFFF);
        chk("bp stall", stall_cnt, 3);
        ex_mem_read = 0; ex_rd = 0;
        drive(0, 32'h0, 32'h0); step();
        chk("bp no dup", out_valid, 0);

        // flush with a coincident hazard
        drive(1, 32'hABCDE337, 32'h120); step();
        chk("lui imm", out_imm, 32'hABCDE000);
        flush = 1; ex_mem_read = 1; ex_rd = 5'd1;
        drive(1, 32'h00208463, 32'h124);
        #1 chk("flush in_ready", in_ready, 0);
        step();
        chk("flush valid", out_valid, 0);
        chk("flush stall", stall_cnt, 3);
        flush = 0; ex_mem_read = 0; ex_rd = 0;
        step();
        chk("beq valid", out_valid, 1);
        chk("beq imm", out_imm, 8);
        chk("beq rw", out_reg_write, 0);

        // asynchronous reset mid-stream
        out_ready = 0;
        drive(0, 32'h0, 32'h0);
        #2 rst_n = 0;
        #1;
        chk("async valid", out_valid, 0);
        chk("async stall", stall_cnt, 0);
        chk("async valid2", out_valid2, 0);
        @(negedge clk);
        rst_n = 1; out_ready = 1;

        // illegal / SYSTEM / misc formats
        drive(1, 32'h0000007F, 32'h200); step();
        chk("ill illegal", out_illegal, 1);
        chk("ill rw", out_reg_write, 0);
        chk("ill mr", out_mem_read, 0);
        chk("ill mw", out_mem_write, 0);
        chk("ill imm", out_imm, 0);
        chk("ill illegal2", out_illegal2, 1);
        drive(1, 32'h00000073, 32'h204); step();
        chk("sys illegal", out_illegal, 0);
        chk("sys illegal2", out_illegal2, 1);
        drive(1, 32'h00812383, 32'h208); step();
        chk("lw mr", out_mem_read, 1);
        chk("lw rw", out_reg_write, 1);
        chk("lw imm", out_imm, 8);
        chk("lw rs1", out_rs1, 2);
        drive(1, 32'hFFDFF06F, 32'h20C); step();
        chk("jal imm", out_imm, 32'hFFFFFFFC);
        chk("jal x0 rw", out_reg_write, 0);
        drive(1, 32'h000280E7, 32'h210); step();
        chk("jalr rw", out_reg_write, 1);
        chk("jalr imm", out_imm, 0);

        // 5 hazard cycles: 16-bit counter reaches 5, 2-bit counter saturates
        ex_mem_read = 1; ex_rd = 5'd5;
        repeat (5) step();
        chk("sat stall", stall_cnt, 5);
        chk("sat stall2", stall_cnt2, 3);
        ex_mem_read = 0; ex_rd = 0;
        drive(0, 32'h0, 32'h0);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
